// File: rtl/median9_sequencer.sv
`default_nettype none
// ============================================================================
// median9_sequencer
//   Median of a 3x3 window using one shared external compare-exchange unit,
//   stepped through a fixed 19-operation selection network.
// Revision: 1.0
// ============================================================================
module median9_sequencer #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [9*DATA_W-1:0]   in_window,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_median,
   output logic                  busy,
   output logic [DATA_W-1:0]     cmp_input1,
   output logic [DATA_W-1:0]     cmp_input2,
   input  logic [DATA_W-1:0]     cmp_max,
   input  logic [DATA_W-1:0]     cmp_min
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SORT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [4:0] LAST_STEP = 5'd18;

   state_t              state;
   logic [4:0]          step;
   logic [DATA_W-1:0]   p [9];
   logic [3:0]          idx_a;
   logic [3:0]          idx_b;

   // Network operation for the current step: p[idx_a] takes the min, p[idx_b] the max.
   always_comb begin
      idx_a = 4'd0;
      idx_b = 4'd0;
      case (step)
         5'd0:  begin idx_a = 4'd1; idx_b = 4'd2; end
         5'd1:  begin idx_a = 4'd4; idx_b = 4'd5; end
         5'd2:  begin idx_a = 4'd7; idx_b = 4'd8; end
         5'd3:  begin idx_a = 4'd0; idx_b = 4'd1; end
         5'd4:  begin idx_a = 4'd3; idx_b = 4'd4; end
         5'd5:  begin idx_a = 4'd6; idx_b = 4'd7; end
         5'd6:  begin idx_a = 4'd1; idx_b = 4'd2; end
         5'd7:  begin idx_a = 4'd4; idx_b = 4'd5; end
         5'd8:  begin idx_a = 4'd7; idx_b = 4'd8; end
         5'd9:  begin idx_a = 4'd0; idx_b = 4'd3; end
         5'd10: begin idx_a = 4'd5; idx_b = 4'd8; end
         5'd11: begin idx_a = 4'd4; idx_b = 4'd7; end
         5'd12: begin idx_a = 4'd3; idx_b = 4'd6; end
         5'd13: begin idx_a = 4'd1; idx_b = 4'd4; end
         5'd14: begin idx_a = 4'd2; idx_b = 4'd5; end
         5'd15: begin idx_a = 4'd4; idx_b = 4'd7; end
         5'd16: begin idx_a = 4'd4; idx_b = 4'd2; end
         5'd17: begin idx_a = 4'd6; idx_b = 4'd4; end
         5'd18: begin idx_a = 4'd4; idx_b = 4'd2; end
         default: begin idx_a = 4'd0; idx_b = 4'd0; end
      endcase
   end

   always_comb begin
      cmp_input1 = '0;
      cmp_input2 = '0;
      if (state == SORT) begin
         cmp_input1 = p[idx_a];
         cmp_input2 = p[idx_b];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         step       <= 5'd0;
         out_valid  <= 1'b0;
         out_median <= '0;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            p[k] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  for (int k = 0; k < 9; k++) begin
                     p[k] <= in_window[DATA_W*k +: DATA_W];
                  end
                  step     <= 5'd0;
                  state    <= SORT;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            SORT: begin
               p[idx_a] <= cmp_min;
               p[idx_b] <= cmp_max;
               if (step == LAST_STEP) begin
                  // The final operation writes p[4], so take the median from the comparator.
                  if (idx_a == 4'd4) begin
                     out_median <= cmp_min;
                  end else if (idx_b == 4'd4) begin
                     out_median <= cmp_max;
                  end else begin
                     out_median <= p[4];
                  end
                  out_valid <= 1'b1;
                  step      <= 5'd0;
                  state     <= DONE;
               end else begin
                  step <= step + 5'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               step      <= 5'd0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_median9_sequencer.sv
`default_nettype none
// ============================================================================
// tb_median9_sequencer
//   Self-checking bench: directed windows plus randomized traffic scored
//   against a sort-based median model.
// Revision: 1.0
// ============================================================================
module tb_median9_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [71:0] in_window;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_median;
   logic        busy;
   logic [7:0]  cmp_input1;
   logic [7:0]  cmp_input2;
   logic [7:0]  cmp_max;
   logic [7:0]  cmp_min;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Shared external comparator
   assign cmp_max = (cmp_input1 > cmp_input2) ? cmp_input1 : cmp_input2;
   assign cmp_min = (cmp_input1 > cmp_input2) ? cmp_input2 : cmp_input1;

   median9_sequencer #(.DATA_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_window  (in_window),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_median (out_median),
      .busy       (busy),
      .cmp_input1 (cmp_input1),
      .cmp_input2 (cmp_input2),
      .cmp_max    (cmp_max),
      .cmp_min    (cmp_min)
   );

   function automatic logic [7:0] median_of(input logic [71:0] w);
      int v [9];
      int t;
      int j;
      for (int k = 0; k < 9; k++) v[k] = int'(w[8*k +: 8]);
      for (int i = 1; i < 9; i++) begin
         j = i;
         while (j > 0 && v[j-1] > v[j]) begin
            t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            j--;
         end
      end
      return 8'(v[4]);
   endfunction

   function automatic logic [71:0] pack9(input logic [7:0] v [9]);
      logic [71:0] r;
      for (int k = 0; k < 9; k++) r[8*k +: 8] = v[k];
      return r;
   endfunction

   // Presents a window until accepted; returns at the negedge after the accept edge.
   task automatic send_window(input logic [71:0] w, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      in_window = w;
      in_valid  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Sends a window with out_ready high; lat = negedges from accept until out_valid seen.
   task automatic run_one(input logic [71:0] w, output logic [7:0] med, output int lat, output bit ok);
      out_ready = 1'b1;
      send_window(w, ok);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) ok = 1'b0;
      med = out_median;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_window = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (out_median !== 8'd0) begin errors++; $display("FAIL reset_out_median: got %0d expected 0", out_median); end
      checks++; if (cmp_input1 !== 8'd0 || cmp_input2 !== 8'd0) begin
         errors++; $display("FAIL reset_cmp_inputs: got %0d/%0d expected 0/0", cmp_input1, cmp_input2);
      end
   endtask

   task automatic test_basic();
      logic [7:0] px [9];
      bit ok;
      int n;
      px = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
      out_ready = 1'b1;
      send_window(pack9(px), ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_accept: got 0 expected 1"); end
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL basic_busy: got busy=%b in_ready=%b expected 1/0", busy, in_ready);
      end
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      // Output handshake edge lands 20 edges after the accept edge.
      checks++; if (n + 1 != 20) begin errors++; $display("FAIL basic_latency: got %0d expected 20", n + 1); end
      checks++; if (out_median !== 8'd5) begin errors++; $display("FAIL basic_median: got %0d expected 5", out_median); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_return_idle: got in_ready=%b out_valid=%b busy=%b expected 1/0/0", in_ready, out_valid, busy);
      end
   endtask

   task automatic test_uniform();
      logic [7:0] vals [3];
      logic [7:0] px [9];
      logic [7:0] med;
      int lat;
      bit ok;
      vals = '{8'hAA, 8'h00, 8'hFF};
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 9; k++) px[k] = vals[i];
         run_one(pack9(px), med, lat, ok);
         checks++; if (!ok || med !== vals[i]) begin
            errors++; $display("FAIL uniform_%0d: got %0d expected %0d", i, med, vals[i]);
         end
      end
   endtask

   task automatic test_extremes();
      logic [7:0] px [9];
      logic [7:0] med;
      int lat;
      bit ok;
      px = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd128};
      run_one(pack9(px), med, lat, ok);
      checks++; if (!ok || med !== 8'd128) begin errors++; $display("FAIL extreme_alt: got %0d expected 128", med); end
      px = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
      run_one(pack9(px), med, lat, ok);
      checks++; if (!ok || med !== 8'd0) begin errors++; $display("FAIL extreme_split: got %0d expected 0", med); end
   endtask

   task automatic test_backpressure();
      logic [7:0] px [9];
      logic [71:0] w2;
      logic [7:0] exp1;
      logic [7:0] exp2;
      bit ok;
      int n;
      px = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd60, 8'd70, 8'd80, 8'd90};
      exp1 = median_of(pack9(px));
      px = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      w2 = pack9(px);
      exp2 = median_of(w2);
      out_ready = 1'b0;
      px = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd60, 8'd70, 8'd80, 8'd90};
      send_window(pack9(px), ok);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++; if (!out_valid) begin errors++; $display("FAIL bp_out_valid_timeout: got 0 expected 1"); end
      in_window = w2;
      in_valid  = 1'b1;
      for (int i = 0; i < 7; i++) begin
         checks++; if (out_valid !== 1'b1 || out_median !== exp1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall_%0d: got valid=%b median=%0d in_ready=%b expected 1/%0d/0", i, out_valid, out_median, in_ready, exp1);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_release: got valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL bp_second_accept: got in_ready=%b busy=%b expected 0/1", in_ready, busy);
      end
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++; if (!out_valid || out_median !== exp2) begin
         errors++; $display("FAIL bp_second_median: got %0d expected %0d", out_median, exp2);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_sort();
      logic [7:0] px [9];
      logic [7:0] med;
      int lat;
      bit ok;
      bit seen;
      px = '{8'd200, 8'd100, 8'd150, 8'd50, 8'd250, 8'd25, 8'd75, 8'd125, 8'd175};
      out_ready = 1'b1;
      send_window(pack9(px), ok);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_idle: got valid=%b busy=%b in_ready=%b expected 0/0/1", out_valid, busy, in_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL midreset_stale_output: got 1 expected 0"); end
      px = '{8'd3, 8'd3, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd9, 8'd5};
      run_one(pack9(px), med, lat, ok);
      checks++; if (!ok || med !== 8'd3) begin errors++; $display("FAIL midreset_median: got %0d expected 3", med); end
   endtask

   task automatic test_random();
      localparam int NWIN = 1500;
      logic [7:0] q [$];
      logic [7:0] exp;
      logic [7:0] px [9];
      int accepted;
      int produced;
      int cyc;
      bit took;
      bit narrow;
      accepted = 0; produced = 0; cyc = 0; took = 1'b1;
      in_valid = 1'b0;
      while (produced < NWIN && cyc < 80000) begin
         @(negedge clk);
         cyc++;
         if (!in_valid || took) begin
            if (accepted < NWIN) begin
               narrow = 1'($urandom_range(0, 1));
               for (int k = 0; k < 9; k++)
                  px[k] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
               in_window = pack9(px);
               in_valid  = ($urandom_range(0, 3) != 0);
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         took = in_valid && in_ready;
         if (took) begin
            q.push_back(median_of(in_window));
            accepted++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rand_unexpected_output: got median %0d with no window outstanding", out_median);
            end else begin
               exp = q.pop_front();
               if (out_median !== exp) begin
                  errors++; $display("FAIL rand_median_%0d: got %0d expected %0d", produced, out_median, exp);
               end
            end
            produced++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++; if (produced != NWIN || accepted != NWIN || q.size() != 0) begin
         errors++; $display("FAIL rand_counts: got accepted=%0d produced=%0d pending=%0d expected %0d/%0d/0", accepted, produced, q.size(), NWIN, NWIN);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_uniform();
      test_extremes();
      test_backpressure();
      test_reset_mid_sort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
